// File: rtl/mvm_layer_param_if.sv
// Handshake bundle for mvm_layer_param: weight stream in, x stream in, y stream out.
interface mvm_layer_param_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] w_data_in;
   logic             w_valid;
   logic             w_ready;
   logic [WIDTH-1:0] s_data_in_x;
   logic             s_valid_x;
   logic             s_ready_x;
   logic [WIDTH-1:0] m_data_out_y;
   logic             m_valid_y;
   logic             m_ready_y;

   // Block side: consumes w and x, produces y.
   modport slave (
      input  w_data_in, w_valid,
      output w_ready,
      input  s_data_in_x, s_valid_x,
      output s_ready_x,
      output m_data_out_y, m_valid_y,
      input  m_ready_y
   );

   // Environment side: produces w and x, consumes y.
   modport master (
      output w_data_in, w_valid,
      input  w_ready,
      output s_data_in_x, s_valid_x,
      input  s_ready_x,
      input  m_data_out_y, m_valid_y,
      output m_ready_y
   );
endinterface

// File: rtl/mvm_layer_param.sv
// Matrix-vector multiply layer: y = post(W * x), P rows evaluated in parallel
// per group, results streamed out in row order.
module mvm_layer_param #(
   parameter int unsigned M     = 8,
   parameter int unsigned N     = 8,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned P     = 2,
   parameter int unsigned RELU  = 1,
   parameter int unsigned SAT   = 1
) (
   input logic              clk,
   input logic              reset,
   mvm_layer_param_if.slave bus
);

   localparam int unsigned G      = M / P;
   localparam int unsigned MN     = M * N;
   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned ACC_W  = 2 * WIDTH + $clog2(N);
   localparam int unsigned WC_W   = (MN > 1) ? $clog2(MN) : 1;
   localparam int unsigned E_W    = (N > 1)  ? $clog2(N)  : 1;
   localparam int unsigned G_W    = (G > 1)  ? $clog2(G)  : 1;
   localparam int unsigned D_W    = (P > 1)  ? $clog2(P)  : 1;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_LOAD_W  = 2'd0,
      S_LOAD_X  = 2'd1,
      S_COMPUTE = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WC_W-1:0] r_w_cnt;
   logic [E_W-1:0]  r_e_cnt;
   logic [G_W-1:0]  r_g_cnt;
   logic [D_W-1:0]  r_d_cnt;
   logic [D_W-1:0]  w_y_idx;

   logic signed [WIDTH-1:0]  r_weights [MN];
   logic signed [WIDTH-1:0]  r_x       [N];
   logic signed [ACC_W-1:0]  r_acc     [P];
   logic signed [PROD_W-1:0] w_prod    [P];

   logic             r_w_ready;
   logic             r_s_ready;
   logic             r_m_valid;
   logic [WIDTH-1:0] r_m_data;

   logic w_w_hs, w_x_hs, w_y_hs;
   logic w_w_last, w_e_last, w_g_last, w_d_last;
   logic w_load_y;

   assign bus.w_ready      = r_w_ready;
   assign bus.s_ready_x    = r_s_ready;
   assign bus.m_valid_y    = r_m_valid;
   assign bus.m_data_out_y = r_m_data;

   assign w_w_hs   = bus.w_valid & r_w_ready;
   assign w_x_hs   = bus.s_valid_x & r_s_ready;
   assign w_y_hs   = r_m_valid & bus.m_ready_y;
   assign w_w_last = (r_w_cnt == WC_W'(MN - 1));
   assign w_e_last = (r_e_cnt == E_W'(N - 1));
   assign w_g_last = (r_g_cnt == G_W'(G - 1));
   assign w_d_last = (r_d_cnt == D_W'(P - 1));

   // Saturate or wrap to WIDTH, then optional ReLU.
   function automatic logic [WIDTH-1:0] post_proc(input logic signed [ACC_W-1:0] a);
      logic signed [WIDTH-1:0] v;
      if ((SAT != 0) && (a > SAT_MAX))      v = SAT_MAX[WIDTH-1:0];
      else if ((SAT != 0) && (a < SAT_MIN)) v = SAT_MIN[WIDTH-1:0];
      else                                  v = a[WIDTH-1:0];
      if ((RELU != 0) && v[WIDTH-1]) v = '0;
      return v;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_LOAD_W;
      else        r_state <= w_state_nxt;
   end

   // Next state and drain-output load control.
   always_comb begin
      w_state_nxt = r_state;
      w_load_y    = 1'b0;
      w_y_idx     = r_d_cnt;
      case (r_state)
         S_LOAD_W:  if (w_w_hs && w_w_last) w_state_nxt = S_LOAD_X;
         S_LOAD_X:  if (w_x_hs && w_e_last) w_state_nxt = S_COMPUTE;
         S_COMPUTE: if (w_e_last)           w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            // First DRAIN cycle fills the empty output register; later ones refill on acceptance.
            if (!r_m_valid) begin
               w_load_y = 1'b1;
            end else if (w_y_hs) begin
               if (w_d_last) begin
                  w_state_nxt = w_g_last ? S_LOAD_X : S_COMPUTE;
               end else begin
                  w_load_y = 1'b1;
                  w_y_idx  = r_d_cnt + D_W'(1);
               end
            end
         end
         default: w_state_nxt = S_LOAD_W;
      endcase
   end

   // Ready flags registered from the next state so they track the state exactly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_w_ready <= 1'b0;
         r_s_ready <= 1'b0;
      end else begin
         r_w_ready <= (w_state_nxt == S_LOAD_W);
         r_s_ready <= (w_state_nxt == S_LOAD_X);
      end
   end

   // Weight, element, group and drain counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_w_cnt <= '0;
         r_e_cnt <= '0;
         r_g_cnt <= '0;
         r_d_cnt <= '0;
      end else begin
         if ((r_state == S_LOAD_W) && w_w_hs)
            r_w_cnt <= w_w_last ? '0 : r_w_cnt + WC_W'(1);
         if (((r_state == S_LOAD_X) && w_x_hs) || (r_state == S_COMPUTE))
            r_e_cnt <= w_e_last ? '0 : r_e_cnt + E_W'(1);
         if ((r_state == S_DRAIN) && w_y_hs) begin
            r_d_cnt <= w_d_last ? '0 : r_d_cnt + D_W'(1);
            if (w_d_last) r_g_cnt <= w_g_last ? '0 : r_g_cnt + G_W'(1);
         end
      end
   end

   // Weight and input-vector storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < MN; i++) r_weights[i] <= '0;
         for (int unsigned i = 0; i < N; i++)  r_x[i]       <= '0;
      end else begin
         if ((r_state == S_LOAD_W) && w_w_hs) r_weights[r_w_cnt] <= bus.w_data_in;
         if ((r_state == S_LOAD_X) && w_x_hs) r_x[r_e_cnt]       <= bus.s_data_in_x;
      end
   end

   // One full-precision product per lane for the current column.
   always_comb begin
      int unsigned idx;
      idx = 0;
      for (int unsigned p = 0; p < P; p++) begin
         idx       = (32'(r_g_cnt) * P + p) * N + 32'(r_e_cnt);
         w_prod[p] = PROD_W'(r_weights[WC_W'(idx)]) * PROD_W'(r_x[r_e_cnt]);
      end
   end

   // Accumulate; column 0 restarts the sum so no separate clear is needed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned p = 0; p < P; p++) r_acc[p] <= '0;
      end else if (r_state == S_COMPUTE) begin
         for (int unsigned p = 0; p < P; p++)
            r_acc[p] <= (r_e_cnt == '0) ? ACC_W'(w_prod[p]) : r_acc[p] + ACC_W'(w_prod[p]);
      end
   end

   // Output register: holds while stalled, clears after the group's last acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
      end else if (w_load_y) begin
         r_m_valid <= 1'b1;
         r_m_data  <= post_proc(r_acc[w_y_idx]);
      end else if (w_y_hs) begin
         r_m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mvm_layer_param.sv
// Bench for mvm_layer_param: two M=4,N=3,P=2 instances (RELU/SAT on and off)
// sharing one stimulus stream, plus a P=4,N=1 instance run on its own.
module tb_mvm_layer_param;

   localparam int M  = 4;
   localparam int N  = 3;
   localparam int MN = M * N;

   logic clk;
   logic rst_ab, rst_c;

   logic [7:0] w_data, x_data;
   logic       w_valid, x_valid, y_ready, y_rand;
   logic [7:0] c_w_data, c_x_data;
   logic       c_w_valid, c_x_valid, c_y_ready;
   bit         c_done;

   int n_chk = 0, n_pass = 0, n_exp = 0, n_got = 0, cyc = 0, xcnt = 0, t_x = 0;
   bit armed = 0, held_a = 0;
   logic [7:0] held_v;

   logic [7:0] wt   [MN];
   logic [7:0] xcur [N];
   logic [7:0] xdir [N];
   logic [7:0] qa [$];
   logic [7:0] qb [$];

   mvm_layer_param_if #(.WIDTH(8)) if_a ();
   mvm_layer_param_if #(.WIDTH(8)) if_b ();
   mvm_layer_param_if #(.WIDTH(8)) if_c ();

   assign if_a.w_data_in   = w_data;
   assign if_a.w_valid     = w_valid;
   assign if_a.s_data_in_x = x_data;
   assign if_a.s_valid_x   = x_valid;
   assign if_a.m_ready_y   = y_ready;
   assign if_b.w_data_in   = w_data;
   assign if_b.w_valid     = w_valid;
   assign if_b.s_data_in_x = x_data;
   assign if_b.s_valid_x   = x_valid;
   assign if_b.m_ready_y   = y_ready;
   assign if_c.w_data_in   = c_w_data;
   assign if_c.w_valid     = c_w_valid;
   assign if_c.s_data_in_x = c_x_data;
   assign if_c.s_valid_x   = c_x_valid;
   assign if_c.m_ready_y   = c_y_ready;

   mvm_layer_param #(.M(4), .N(3), .WIDTH(8), .P(2), .RELU(1), .SAT(1))
      u_a (.clk(clk), .reset(rst_ab), .bus(if_a.slave));
   mvm_layer_param #(.M(4), .N(3), .WIDTH(8), .P(2), .RELU(0), .SAT(0))
      u_b (.clk(clk), .reset(rst_ab), .bus(if_b.slave));
   mvm_layer_param #(.M(4), .N(1), .WIDTH(8), .P(4), .RELU(1), .SAT(1))
      u_c (.clk(clk), .reset(rst_c), .bus(if_c.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output ready: always 1, or random when y_rand is set.
   always @(posedge clk) begin
      #1;
      y_ready = y_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
   endtask

   // Reference: exact integer dot product, then saturate/wrap, then ReLU.
   function automatic logic [7:0] ref_y(input int r, input bit sat, input bit relu);
      int s, v;
      logic [7:0] lo;
      s = 0;
      for (int k = 0; k < N; k++)
         s += int'($signed(wt[r*N+k])) * int'($signed(xcur[k]));
      lo = s[7:0];
      if (sat) v = (s > 127) ? 127 : ((s < -128) ? -128 : s);
      else     v = int'($signed(lo));
      if (relu && v < 0) v = 0;
      return v[7:0];
   endfunction

   // Output scoreboard, stall stability and x-to-y latency, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_ab) begin
         xcnt   = 0;
         armed  = 0;
         held_a = 0;
      end else begin
         if (armed && if_a.m_valid_y) begin
            chk("latency", 32'(cyc - t_x), 32'(N + 1));
            armed = 0;
         end
         if (x_valid && if_a.s_ready_x) begin
            if (xcnt == N - 1) begin
               xcnt  = 0;
               t_x   = cyc + 1;
               armed = 1;
            end else begin
               xcnt++;
            end
         end
         if (held_a) begin
            chk("hold_valid", 32'(if_a.m_valid_y), 32'd1);
            chk("hold_data", 32'(if_a.m_data_out_y), 32'(held_v));
         end
         held_a = if_a.m_valid_y && !y_ready;
         held_v = if_a.m_data_out_y;
         if (if_a.m_valid_y && y_ready) begin
            n_got++;
            if (qa.size() == 0) chk("a_extra", 32'd1, 32'd0);
            else                chk("a_y", 32'(if_a.m_data_out_y), 32'(qa.pop_front()));
         end
         if (if_b.m_valid_y && y_ready) begin
            if (qb.size() == 0) chk("b_extra", 32'd1, 32'd0);
            else                chk("b_y", 32'(if_b.m_data_out_y), 32'(qb.pop_front()));
         end
      end
   end

   task automatic do_reset();
      rst_ab = 1'b0;
      #1;
      qa.delete();
      qb.delete();
      n_exp = n_got;
      repeat (2) @(posedge clk);
      #1 rst_ab = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Stream wt[] in; junk x is offered meanwhile and must be ignored.
   task automatic load_w(input bit rnd);
      int i, g;
      i = 0;
      g = 0;
      while (i < MN && g < 1000) begin
         w_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         w_data  = w_valid ? wt[i] : 8'($urandom);
         x_valid = 1'($urandom_range(0, 1));
         x_data  = 8'($urandom);
         @(negedge clk);
         if (w_valid && if_a.w_ready) i++;
         @(posedge clk);
         #1;
         g++;
      end
      w_valid = 1'b0;
      x_valid = 1'b0;
      if (i < MN) chk("w_timeout", 32'd0, 32'd1);
   endtask

   // Stream nvec vectors; junk weights are offered meanwhile and must be ignored.
   task automatic drive_vectors(input int nvec, input bit rnd);
      int g;
      bit hs;
      for (int v = 0; v < nvec; v++) begin
         for (int k = 0; k < N; k++) xcur[k] = rnd ? 8'($urandom) : xdir[k];
         for (int k = 0; k < N; k++) begin
            g = 0;
            do begin
               x_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
               x_data  = x_valid ? xcur[k] : 8'($urandom);
               w_valid = 1'($urandom_range(0, 1));
               w_data  = 8'($urandom);
               @(negedge clk);
               hs = x_valid && if_a.s_ready_x;
               if (hs && k == N - 1) begin
                  for (int r = 0; r < M; r++) begin
                     qa.push_back(ref_y(r, 1'b1, 1'b1));
                     qb.push_back(ref_y(r, 1'b0, 1'b0));
                  end
                  n_exp += M;
               end
               @(posedge clk);
               #1;
               g++;
            end while (!hs && g < 2000);
            if (!hs) begin
               chk("x_timeout", 32'd0, 32'd1);
               x_valid = 1'b0;
               w_valid = 1'b0;
               return;
            end
         end
      end
      x_valid = 1'b0;
      w_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while ((qa.size() != 0 || qb.size() != 0) && g < 5000) begin
         @(posedge clk);
         g++;
      end
      #1;
      if (g >= 5000) chk("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic directed(input logic [7:0] wv, input logic [7:0] x0,
                           input logic [7:0] x1, input logic [7:0] x2);
      do_reset();
      for (int i = 0; i < MN; i++) wt[i] = wv;
      xdir[0] = x0;
      xdir[1] = x1;
      xdir[2] = x2;
      load_w(1'b0);
      drive_vectors(1, 1'b0);
      wait_drain();
   endtask

   // Main sequence on the shared A/B stream.
   initial begin
      int g, base;
      rst_ab  = 1'b0;
      w_valid = 1'b0;
      x_valid = 1'b0;
      w_data  = '0;
      x_data  = '0;
      y_ready = 1'b1;
      y_rand  = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_w_ready", 32'(if_a.w_ready), 32'd0);
      chk("rst_s_ready", 32'(if_a.s_ready_x), 32'd0);
      chk("rst_m_valid", 32'(if_a.m_valid_y), 32'd0);
      chk("rst_m_data", 32'(if_a.m_data_out_y), 32'd0);
      chk("rst_b_valid", 32'(if_b.m_valid_y), 32'd0);
      @(posedge clk);
      #1 rst_ab = 1'b1;
      chk("w_ready_pre", 32'(if_a.w_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("w_ready_post", 32'(if_a.w_ready), 32'd1);

      directed(8'd1,   8'd1,   8'd2,   8'd3);
      directed(8'd127, 8'd127, 8'd127, 8'd127);
      directed(8'hFF,  8'd1,   8'd2,   8'd3);

      // Random weights, 100 random vectors, random valid/ready everywhere.
      do_reset();
      for (int i = 0; i < MN; i++) wt[i] = 8'($urandom);
      load_w(1'b1);
      y_rand = 1'b1;
      drive_vectors(100, 1'b1);
      wait_drain();
      y_rand = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset while group 1 is computing.
      for (int k = 0; k < N; k++) xdir[k] = 8'($urandom);
      drive_vectors(1, 1'b0);
      base = n_got;
      g = 0;
      while (n_got < base + 2 && g < 200) begin
         @(posedge clk);
         g++;
      end
      if (g >= 200) chk("g0_timeout", 32'd0, 32'd1);
      #1;
      @(posedge clk);
      #1 rst_ab = 1'b0;
      #1;
      chk("mid_w_ready", 32'(if_a.w_ready), 32'd0);
      chk("mid_s_ready", 32'(if_a.s_ready_x), 32'd0);
      chk("mid_m_valid", 32'(if_a.m_valid_y), 32'd0);
      chk("mid_m_data", 32'(if_a.m_data_out_y), 32'd0);
      chk("mid_b_valid", 32'(if_b.m_valid_y), 32'd0);
      qa.delete();
      qb.delete();
      n_exp = n_got;
      repeat (3) @(posedge clk);
      #1 rst_ab = 1'b1;
      chk("rel_w_ready_pre", 32'(if_a.w_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rel_w_ready_post", 32'(if_a.w_ready), 32'd1);
      repeat (10) @(posedge clk);
      #1;

      // Fresh weights after reset, a few more vectors.
      for (int i = 0; i < MN; i++) wt[i] = 8'($urandom);
      load_w(1'b1);
      y_rand = 1'b1;
      drive_vectors(5, 1'b1);
      wait_drain();
      y_rand = 1'b0;

      chk("out_count", 32'(n_got), 32'(n_exp));
      chk("qb_empty", 32'(qb.size()), 32'd0);

      g = 0;
      while (!c_done && g < 1000) begin
         @(posedge clk);
         g++;
      end
      if (!c_done) chk("c_timeout", 32'd0, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // P=4, N=1 instance: weight row r = r+1, x = {2} -> y = {2,4,6,8}.
   initial begin
      int g;
      c_done    = 1'b0;
      rst_c     = 1'b0;
      c_w_valid = 1'b0;
      c_x_valid = 1'b0;
      c_w_data  = '0;
      c_x_data  = '0;
      c_y_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         c_w_data  = 8'(i + 1);
         c_w_valid = 1'b1;
         g = 0;
         @(negedge clk);
         while (!if_c.w_ready && g < 50) begin
            g++;
            @(negedge clk);
         end
         if (g >= 50) chk("c_w_timeout", 32'd0, 32'd1);
         @(posedge clk);
         #1;
      end
      c_w_valid = 1'b0;
      c_x_data  = 8'd2;
      c_x_valid = 1'b1;
      g = 0;
      @(negedge clk);
      while (!if_c.s_ready_x && g < 50) begin
         g++;
         @(negedge clk);
      end
      if (g >= 50) chk("c_x_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 c_x_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         g = 0;
         @(negedge clk);
         while (!if_c.m_valid_y && g < 50) begin
            g++;
            @(negedge clk);
         end
         if (g >= 50) chk("c_y_timeout", 32'd0, 32'd1);
         chk("c_y", 32'(if_c.m_data_out_y), 32'(2 * (k + 1)));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("c_done_valid", 32'(if_c.m_valid_y), 32'd0);
      chk("c_back_load_x", 32'(if_c.s_ready_x), 32'd1);
      c_done = 1'b1;
   end

endmodule
